vtiming_ctrl: RTL and testbench

//  Raster sequencer for the VGA output path. Generates PixelCnt/LineCnt and the active-area flags that feed
//  the sync/blank generator (vsig), with run-time reprogrammable H/V totals and active sizes.
//  A new mode is accepted over a valid/ready handshake and is applied only at a frame boundary, so the

---
 rtl/vtiming_pkg.sv | 24 ++
 rtl/vtiming_axis.sv | 44 ++++
 rtl/vtiming_ctrl.sv | 133 +++++++++++++
 tb/tb_vtiming_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vtiming_pkg.sv
// Shared definitions for the VGA raster sequencer: 640x480@60 defaults, FSM encoding, mode validity check.
package vtiming_pkg;

   localparam int unsigned HACT = 640;
   localparam int unsigned HTOT = 800;
   localparam int unsigned VACT = 480;
   localparam int unsigned VTOT = 525;

   // Config fields are zero-extended to this width before the validity check.
   localparam int unsigned CFGW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   function automatic logic cfg_ok(input logic [CFGW-1:0] hact, input logic [CFGW-1:0] htot,
                                   input logic [CFGW-1:0] vact, input logic [CFGW-1:0] vtot);
      return (hact != '0) && (hact < htot) && (htot >= CFGW'(2)) &&
             (vact != '0) && (vact < vtot) && (vtot >= CFGW'(2));
   endfunction

endpackage

// File: rtl/vtiming_axis.sv
// One raster axis: wrapping counter plus registered active/zero flags that track the counter value.
module vtiming_axis #(
   parameter int unsigned W = 10
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Step,
   input  logic         Clear,
   input  logic [W-1:0] Tot,
   input  logic [W-1:0] Act,
   output logic [W-1:0] Cnt,
   output logic         IsAct,
   output logic         Last,
   output logic         Zero
);

   logic [W-1:0] cnt_nxt;

   // Tot is the timing in force this cycle; Act is the one in force next cycle.
   assign Last = (Cnt == Tot - W'(1));

   always_comb begin
      cnt_nxt = Cnt;
      if (Clear) begin
         cnt_nxt = '0;
      end else if (Step) begin
         cnt_nxt = Last ? '0 : Cnt + W'(1);
      end
   end

   // Flags are qualified by Clear so they read 0 while the sequencer is idle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Cnt   <= '0;
         IsAct <= 1'b0;
         Zero  <= 1'b0;
      end else begin
         Cnt   <= cnt_nxt;
         IsAct <= !Clear && (cnt_nxt < Act);
         Zero  <= !Clear && (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/vtiming_ctrl.sv
// VGA raster sequencer: H/V counters, active flags and line/frame strobes with frame-aligned mode updates.
module vtiming_ctrl
   import vtiming_pkg::*;
#(
   parameter int unsigned XWIDTH   = 10,
   parameter int unsigned YWIDTH   = 10,
   parameter int unsigned HACT_DEF = HACT,
   parameter int unsigned HTOT_DEF = HTOT,
   parameter int unsigned VACT_DEF = VACT,
   parameter int unsigned VTOT_DEF = VTOT
) (
   input  logic              PixelClk,
   input  logic              Reset,
   input  logic              Enable,
   input  logic [XWIDTH-1:0] CfgHAct,
   input  logic [XWIDTH-1:0] CfgHTot,
   input  logic [YWIDTH-1:0] CfgVAct,
   input  logic [YWIDTH-1:0] CfgVTot,
   input  logic              CfgValid,
   output logic              CfgReady,
   output logic              CfgErr,
   output logic [XWIDTH-1:0] PixelCnt,
   output logic [YWIDTH-1:0] LineCnt,
   output logic              IsActHorz,
   output logic              IsActVert,
   output logic              LineStart,
   output logic              FrameStart,
   output logic              Running
);

   state_e state, state_nxt;

   logic [XWIDTH-1:0] hact, htot, sh_hact, sh_htot, hact_nxt, htot_nxt;
   logic [YWIDTH-1:0] vact, vtot, sh_vact, sh_vtot, vact_nxt, vtot_nxt;
   logic pending, pending_nxt;
   logic counting, wrap, clear, xfer, ok, apply;
   logic h_last, v_last, v_zero_unused;

   assign counting = (state != ST_IDLE);
   assign wrap     = counting && h_last && v_last;
   assign clear    = (state_nxt == ST_IDLE);

   assign xfer  = CfgValid && CfgReady;
   assign ok    = cfg_ok(CFGW'(CfgHAct), CFGW'(CfgHTot), CFGW'(CfgVAct), CFGW'(CfgVTot));
   // Shadow lands immediately when idle, otherwise only on the frame-wrap edge.
   assign apply = pending && (!counting || wrap);

   assign hact_nxt    = apply ? sh_hact : hact;
   assign htot_nxt    = apply ? sh_htot : htot;
   assign vact_nxt    = apply ? sh_vact : vact;
   assign vtot_nxt    = apply ? sh_vtot : vtot;
   assign pending_nxt = (pending && !apply) || (xfer && ok);

   always_ff @(posedge PixelClk or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (Enable) state_nxt = ST_RUN;
         ST_RUN:  if (!Enable) state_nxt = ST_STOP;
         ST_STOP: begin
            if (Enable)    state_nxt = ST_RUN;
            else if (wrap) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge PixelClk or posedge Reset) begin
      if (Reset) begin
         hact       <= XWIDTH'(HACT_DEF);
         htot       <= XWIDTH'(HTOT_DEF);
         vact       <= YWIDTH'(VACT_DEF);
         vtot       <= YWIDTH'(VTOT_DEF);
         sh_hact    <= '0;
         sh_htot    <= '0;
         sh_vact    <= '0;
         sh_vtot    <= '0;
         pending    <= 1'b0;
         CfgReady   <= 1'b1;
         CfgErr     <= 1'b0;
         Running    <= 1'b0;
         FrameStart <= 1'b0;
      end else begin
         hact <= hact_nxt;
         htot <= htot_nxt;
         vact <= vact_nxt;
         vtot <= vtot_nxt;
         if (xfer && ok) begin
            sh_hact <= CfgHAct;
            sh_htot <= CfgHTot;
            sh_vact <= CfgVAct;
            sh_vtot <= CfgVTot;
         end
         pending    <= pending_nxt;
         CfgReady   <= !pending_nxt;
         CfgErr     <= xfer && !ok;
         Running    <= !clear;
         // Next cycle shows (0,0) either on leaving IDLE or after a frame wrap.
         FrameStart <= !clear && (!counting || wrap);
      end
   end

   vtiming_axis #(.W(XWIDTH)) u_haxis (
      .Clk   (PixelClk),
      .Reset (Reset),
      .Step  (counting),
      .Clear (clear),
      .Tot   (htot),
      .Act   (hact_nxt),
      .Cnt   (PixelCnt),
      .IsAct (IsActHorz),
      .Last  (h_last),
      .Zero  (LineStart)
   );

   vtiming_axis #(.W(YWIDTH)) u_vaxis (
      .Clk   (PixelClk),
      .Reset (Reset),
      .Step  (h_last && counting),
      .Clear (clear),
      .Tot   (vtot),
      .Act   (vact_nxt),
      .Cnt   (LineCnt),
      .IsAct (IsActVert),
      .Last  (v_last),
      .Zero  (v_zero_unused)
   );

endmodule

// File: tb/tb_vtiming_ctrl.sv
// Scoreboard bench for vtiming_ctrl: a frame-position reference model predicts every cycle's outputs.
module tb_vtiming_ctrl;

   localparam int unsigned XW = 10;
   localparam int unsigned YW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic cv  = 1'b0;
   logic [XW-1:0] c_ha = '0, c_ht = '0;
   logic [YW-1:0] c_va = '0, c_vt = '0;

   logic          CfgReady, CfgErr, IsActHorz, IsActVert, LineStart, FrameStart, Running;
   logic [XW-1:0] PixelCnt;
   logic [YW-1:0] LineCnt;

   always #5 clk = ~clk;

   vtiming_ctrl #(.XWIDTH(XW), .YWIDTH(YW)) dut (
      .PixelClk   (clk),
      .Reset      (rst),
      .Enable     (en),
      .CfgHAct    (c_ha),
      .CfgHTot    (c_ht),
      .CfgVAct    (c_va),
      .CfgVTot    (c_vt),
      .CfgValid   (cv),
      .CfgReady   (CfgReady),
      .CfgErr     (CfgErr),
      .PixelCnt   (PixelCnt),
      .LineCnt    (LineCnt),
      .IsActHorz  (IsActHorz),
      .IsActVert  (IsActVert),
      .LineStart  (LineStart),
      .FrameStart (FrameStart),
      .Running    (Running)
   );

   typedef struct packed {
      logic [XW-1:0] pix;
      logic [YW-1:0] line;
      logic ah, av, ls, fs, run, rdy, err;
   } obs_t;

   obs_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a running flag, a stop request and a linear position within the frame.
   int m_ha, m_ht, m_va, m_vt;
   int s_ha, s_ht, s_va, s_vt;
   bit m_pend, m_run, m_stop, m_err;
   int m_pos;

   function automatic bit rule_ok(input int ha, input int ht, input int va, input int vt);
      return ha >= 1 && ha < ht && ht >= 2 && va >= 1 && va < vt && vt >= 2;
   endfunction

   always @(posedge clk) begin : model
      obs_t e;
      bit wrap, xfer, ok, apply;
      if (rst) begin
         m_ha = 640; m_ht = 800; m_va = 480; m_vt = 525;
         s_ha = 0; s_ht = 0; s_va = 0; s_vt = 0;
         m_pend = 0; m_run = 0; m_stop = 0; m_err = 0; m_pos = 0;
      end else begin
         wrap  = m_run && (m_pos == m_ht * m_vt - 1);
         xfer  = cv && !m_pend;
         ok    = rule_ok(int'(c_ha), int'(c_ht), int'(c_va), int'(c_vt));
         m_err = xfer && !ok;
         apply = m_pend && (!m_run || wrap);
         if (!m_run) begin
            m_run = en; m_stop = 0; m_pos = 0;
         end else if (m_stop && !en && wrap) begin
            m_run = 0; m_stop = 0; m_pos = 0;
         end else begin
            m_stop = !en;
            m_pos  = wrap ? 0 : m_pos + 1;
         end
         if (apply) begin
            m_ha = s_ha; m_ht = s_ht; m_va = s_va; m_vt = s_vt; m_pend = 0;
         end
         if (xfer && ok) begin
            s_ha = int'(c_ha); s_ht = int'(c_ht); s_va = int'(c_va); s_vt = int'(c_vt); m_pend = 1;
         end
      end
      e = '0;
      if (m_run) begin
         e.pix  = XW'(m_pos % m_ht);
         e.line = YW'(m_pos / m_ht);
         e.ah   = (m_pos % m_ht) < m_ha;
         e.av   = (m_pos / m_ht) < m_va;
         e.ls   = (m_pos % m_ht) == 0;
         e.fs   = (m_pos == 0);
      end
      e.run = m_run;
      e.rdy = !m_pend;
      e.err = m_err;
      q.push_back(e);
   end

   always @(posedge clk) begin : monitor
      obs_t a, e;
      #1;
      a = {PixelCnt, LineCnt, IsActHorz, IsActVert, LineStart, FrameStart, Running, CfgReady, CfgErr};
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty t=%0t: DUT output with no expected entry", $time);
      end else begin
         e = q.pop_front();
         if (a !== e) begin
            n_bad++;
            $display("FAIL outputs t=%0t: got pix=%0d line=%0d ah=%b av=%b ls=%b fs=%b run=%b rdy=%b err=%b, expected pix=%0d line=%0d ah=%b av=%b ls=%b fs=%b run=%b rdy=%b err=%b",
                     $time, a.pix, a.line, a.ah, a.av, a.ls, a.fs, a.run, a.rdy, a.err,
                     e.pix, e.line, e.ah, e.av, e.ls, e.fs, e.run, e.rdy, e.err);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic offer(input int ha, input int ht, input int va, input int vt);
      c_ha = XW'(ha); c_ht = XW'(ht); c_va = YW'(va); c_vt = YW'(vt);
      cv = 1'b1;
      @(negedge clk);
      cv = 1'b0;
   endtask

   task automatic timeout_fail(input string what, input int lim);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: condition not reached within %0d cycles, required to occur", what, lim);
   endtask

   task automatic wait_pos(input int px, input int ln, input int lim);
      int k = 0;
      while (!(m_run && (m_pos % m_ht) == px && (m_pos / m_ht) == ln) && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (k >= lim) timeout_fail("wait_pos", lim);
   endtask

   task automatic wait_last(input int lim);
      int k = 0;
      while (!(m_run && m_pos == m_ht * m_vt - 1 && !m_pend) && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (k >= lim) timeout_fail("wait_last", lim);
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (m_run && k < lim) begin
         @(negedge clk);
         k++;
      end
      if (k >= lim) timeout_fail("wait_idle", lim);
   endtask

   initial begin : stim
      int ha, ht, va, vt;
      cyc(2);
      rst = 1'b0;
      cyc(5);
      // Default 640x800 / 480x525 timing over the first few lines.
      en = 1'b1;
      cyc(2000);
      // Pending mode discarded by a mid-frame reset; restart on defaults.
      offer(3, 6, 2, 4);
      cyc(20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cyc(1700);
      // Program 8x5 (act 4x3) while idle.
      rst = 1'b1; en = 1'b0;
      cyc(1);
      rst = 1'b0;
      cyc(2);
      offer(4, 8, 3, 5);
      cyc(3);
      en = 1'b1;
      cyc(120);
      // Rejected modes.
      offer(800, 800, 3, 5); cyc(3);
      offer(1, 1, 1, 2);     cyc(2);
      offer(4, 8, 0, 5);     cyc(2);
      offer(4, 8, 5, 5);     cyc(2);
      offer(0, 8, 3, 5);     cyc(10);
      // Mid-frame change to 6x4 (act 3x2).
      wait_pos(2, 1, 100);
      offer(3, 6, 2, 4);
      cyc(80);
      // Transfer on the frame-wrap edge back to 8x5.
      wait_last(100);
      offer(4, 8, 3, 5);
      cyc(60);
      // Enable dropped at (3,1): finish the frame, then idle.
      wait_pos(3, 1, 100);
      en = 1'b0;
      wait_idle(100);
      cyc(5);
      en = 1'b1;
      cyc(50);
      // Brief stop that resumes before the wrap.
      en = 1'b0; cyc(5); en = 1'b1;
      cyc(50);
      // Pending shadow applied as the block drops into IDLE.
      en = 1'b0;
      offer(3, 6, 2, 4);
      wait_idle(100);
      cyc(3);
      en = 1'b1;
      cyc(40);
      // Randomized enable and config traffic over small modes.
      repeat (1500) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) begin
            ht = $urandom_range(1, 12);
            ha = $urandom_range(0, ht);
            vt = $urandom_range(1, 8);
            va = $urandom_range(0, vt);
            c_ha = XW'(ha); c_ht = XW'(ht); c_va = YW'(va); c_vt = YW'(vt);
            cv = 1'b1;
         end else begin
            cv = 1'b0;
         end
         @(negedge clk);
      end
      cv = 1'b0;
      en = 1'b0;
      wait_idle(200);
      cyc(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
